// File: rtl/e203_dtcm_ram_arb.sv
// DTCM SRAM front end: round-robin arbitration between two ICB-style requesters,
// a one-deep response stage with a hold register, and idle-driven light sleep.
module e203_dtcm_ram_arb #(
  parameter int AW          = 14,
  parameter int DW          = 32,
  parameter int MW          = 4,
  parameter int IDLE_LS_CYC = 16
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          m0_cmd_valid,
  output logic          m0_cmd_ready,
  input  logic          m0_cmd_read,
  input  logic [AW-1:0] m0_cmd_addr,
  input  logic [DW-1:0] m0_cmd_wdata,
  input  logic [MW-1:0] m0_cmd_wmask,
  output logic          m0_rsp_valid,
  input  logic          m0_rsp_ready,
  output logic [DW-1:0] m0_rsp_rdata,

  input  logic          m1_cmd_valid,
  output logic          m1_cmd_ready,
  input  logic          m1_cmd_read,
  input  logic [AW-1:0] m1_cmd_addr,
  input  logic [DW-1:0] m1_cmd_wdata,
  input  logic [MW-1:0] m1_cmd_wmask,
  output logic          m1_rsp_valid,
  input  logic          m1_rsp_ready,
  output logic [DW-1:0] m1_rsp_rdata,

  output logic          ram_cs,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [MW-1:0] ram_wem,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic          ram_ls,
  output logic          ram_ds,
  output logic          ram_sd
);

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_SLEEP  = 2'd1,
    ST_WAKE   = 2'd2
  } state_t;

  localparam bit         LS_EN   = (IDLE_LS_CYC != 0);
  localparam logic [7:0] LS_LAST = 8'(IDLE_LS_CYC - 1);

  state_t        state;
  logic          ls_q;
  logic [7:0]    idle_cnt;
  logic          rr_ptr;
  logic          pend;
  logic          owner;
  logic          is_rd;
  logic          first_q;
  logic [DW-1:0] hold_q;

  logic          owner_rdy;
  logic          free;
  logic          can_gnt;
  logic          gnt0;
  logic          gnt1;
  logic          gnt;
  logic          sel_rd;
  logic          idle;
  logic [DW-1:0] rsp_data;

  always_comb begin
    owner_rdy = owner ? m1_rsp_ready : m0_rsp_ready;
    free      = !pend | owner_rdy;
    can_gnt   = (state == ST_ACTIVE) & free;
    gnt0      = can_gnt & m0_cmd_valid & (!m1_cmd_valid | !rr_ptr);
    gnt1      = can_gnt & m1_cmd_valid & (!m0_cmd_valid |  rr_ptr);
    gnt       = gnt0 | gnt1;
    sel_rd    = gnt1 ? m1_cmd_read : m0_cmd_read;
    idle      = (state == ST_ACTIVE) & !gnt & !pend & !m0_cmd_valid & !m1_cmd_valid;
    // Fresh RAM output is only valid in the first response cycle; after that the captured copy is used.
    if (!is_rd)
      rsp_data = '0;
    else if (first_q)
      rsp_data = ram_dout;
    else
      rsp_data = hold_q;
  end

  assign m0_cmd_ready = gnt0;
  assign m1_cmd_ready = gnt1;

  assign ram_cs   = gnt;
  assign ram_we   = gnt & !sel_rd;
  assign ram_addr = gnt1 ? m1_cmd_addr  : (gnt0 ? m0_cmd_addr  : '0);
  assign ram_din  = gnt1 ? m1_cmd_wdata : (gnt0 ? m0_cmd_wdata : '0);
  assign ram_wem  = ram_we ? (gnt1 ? m1_cmd_wmask : m0_cmd_wmask) : '0;
  assign ram_ls   = ls_q;
  assign ram_ds   = 1'b0;
  assign ram_sd   = 1'b0;

  assign m0_rsp_valid = pend & !owner;
  assign m1_rsp_valid = pend &  owner;
  assign m0_rsp_rdata = (pend & !owner) ? rsp_data : '0;
  assign m1_rsp_rdata = (pend &  owner) ? rsp_data : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr  <= 1'b0;
      pend    <= 1'b0;
      owner   <= 1'b0;
      is_rd   <= 1'b0;
      first_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      first_q <= gnt;
      if (gnt) begin
        pend  <= 1'b1;
        owner <= gnt1;
        is_rd <= sel_rd;
        if (m0_cmd_valid & m1_cmd_valid)
          rr_ptr <= ~rr_ptr;
      end else if (pend & owner_rdy) begin
        pend <= 1'b0;
      end
      if (pend & first_q & !owner_rdy)
        hold_q <= ram_dout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_ACTIVE;
      ls_q     <= 1'b0;
      idle_cnt <= '0;
    end else begin
      case (state)
        ST_ACTIVE: begin
          if (idle) begin
            if (LS_EN && (idle_cnt == LS_LAST)) begin
              state    <= ST_SLEEP;
              ls_q     <= 1'b1;
              idle_cnt <= '0;
            end else begin
              idle_cnt <= idle_cnt + 8'd1;
            end
          end else begin
            idle_cnt <= '0;
          end
        end
        ST_SLEEP: begin
          if (m0_cmd_valid | m1_cmd_valid) begin
            state <= ST_WAKE;
            ls_q  <= 1'b0;
          end
        end
        ST_WAKE: begin
          state <= ST_ACTIVE;
        end
        default: begin
          state <= ST_ACTIVE;
          ls_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_e203_dtcm_ram_arb.sv
// Scoreboard bench for e203_dtcm_ram_arb: directed scenarios plus randomized
// traffic checked against a word-addressed memory model.
module tb_e203_dtcm_ram_arb;
  localparam int AW = 14;
  localparam int DW = 32;
  localparam int MW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          m0_cmd_valid, m0_cmd_ready, m0_cmd_read, m0_rsp_valid, m0_rsp_ready;
  logic [AW-1:0] m0_cmd_addr;
  logic [DW-1:0] m0_cmd_wdata, m0_rsp_rdata;
  logic [MW-1:0] m0_cmd_wmask;
  logic          m1_cmd_valid, m1_cmd_ready, m1_cmd_read, m1_rsp_valid, m1_rsp_ready;
  logic [AW-1:0] m1_cmd_addr;
  logic [DW-1:0] m1_cmd_wdata, m1_rsp_rdata;
  logic [MW-1:0] m1_cmd_wmask;
  logic          ram_cs, ram_we, ram_ls, ram_ds, ram_sd;
  logic [AW-1:0] ram_addr;
  logic [MW-1:0] ram_wem;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout = '0;

  e203_dtcm_ram_arb #(.AW(AW), .DW(DW), .MW(MW), .IDLE_LS_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_cmd_valid(m0_cmd_valid), .m0_cmd_ready(m0_cmd_ready), .m0_cmd_read(m0_cmd_read),
    .m0_cmd_addr(m0_cmd_addr), .m0_cmd_wdata(m0_cmd_wdata), .m0_cmd_wmask(m0_cmd_wmask),
    .m0_rsp_valid(m0_rsp_valid), .m0_rsp_ready(m0_rsp_ready), .m0_rsp_rdata(m0_rsp_rdata),
    .m1_cmd_valid(m1_cmd_valid), .m1_cmd_ready(m1_cmd_ready), .m1_cmd_read(m1_cmd_read),
    .m1_cmd_addr(m1_cmd_addr), .m1_cmd_wdata(m1_cmd_wdata), .m1_cmd_wmask(m1_cmd_wmask),
    .m1_rsp_valid(m1_rsp_valid), .m1_rsp_ready(m1_rsp_ready), .m1_rsp_rdata(m1_rsp_rdata),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wem(ram_wem),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_ls(ram_ls), .ram_ds(ram_ds), .ram_sd(ram_sd)
  );

  // SRAM macro: registered read data, byte-masked writes.
  logic [31:0] macro_mem [0:63];
  always @(posedge clk) begin
    logic [31:0] w;
    if (ram_cs) begin
      if (ram_we) begin
        w = macro_mem[ram_addr[5:0]];
        for (int b = 0; b < 4; b++)
          if (ram_wem[b]) w[b*8 +: 8] = ram_din[b*8 +: 8];
        macro_mem[ram_addr[5:0]] <= w;
      end else begin
        ram_dout <= macro_mem[ram_addr[5:0]];
      end
    end
  end

  // Reference: memory contents as seen by requesters, and expected responses in order.
  typedef struct {
    logic        port;
    logic [31:0] data;
  } exp_t;
  logic [31:0] gold_mem [0:63];
  exp_t        sbq[$];
  logic        rr_exp;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  logic [1:0]  mv, mr, mcv, mcr, macc;
  logic [31:0] mdat [2];
  always @(negedge clk) begin
    if (!rst_n) begin
      sbq.delete();
      rr_exp = 1'b0;
    end else begin
      mv = {m1_rsp_valid, m0_rsp_valid};
      mr = {m1_rsp_ready, m0_rsp_ready};
      mcv = {m1_cmd_valid, m0_cmd_valid};
      mcr = {m1_cmd_ready, m0_cmd_ready};
      mdat[0] = m0_rsp_rdata;
      mdat[1] = m1_rsp_rdata;
      for (int p = 0; p < 2; p++) begin
        logic due;
        due = (sbq.size() != 0) && (sbq[0].port == p[0]);
        chk("rsp_valid", mv[p], due);
        if (mv[p] && due) chk("rsp_rdata", mdat[p], sbq[0].data);
        if (mv[p] && !mr[p]) begin
          chk("stall_cmd_ready", mcr, 2'b00);
          chk("stall_ram_cs", ram_cs, 1'b0);
        end
      end
      if (sbq.size() != 0 && mv[sbq[0].port] && mr[sbq[0].port]) void'(sbq.pop_front());
      macc = mcv & mcr;
      chk("single_grant", mcr == 2'b11, 1'b0);
      if (macc == 2'b00) begin
        chk("ram_cs_idle", ram_cs, 1'b0);
      end else begin
        logic          p;
        logic          rd;
        logic [AW-1:0] a;
        logic [31:0]   d, w;
        logic [3:0]    m;
        p  = macc[1];
        rd = p ? m1_cmd_read  : m0_cmd_read;
        a  = p ? m1_cmd_addr  : m0_cmd_addr;
        d  = p ? m1_cmd_wdata : m0_cmd_wdata;
        m  = p ? m1_cmd_wmask : m0_cmd_wmask;
        chk("ram_cs_grant", ram_cs, 1'b1);
        chk("ram_addr", ram_addr, a);
        chk("ram_we", ram_we, !rd);
        chk("ram_wem", ram_wem, rd ? 4'h0 : m);
        if (!rd) chk("ram_din", ram_din, d);
        if (mcv == 2'b11) begin
          chk("rr_order", p, rr_exp);
          rr_exp = ~p;
        end
        if (rd) begin
          sbq.push_back('{port: p, data: gold_mem[a[5:0]]});
        end else begin
          w = gold_mem[a[5:0]];
          for (int b = 0; b < 4; b++)
            if (m[b]) w[b*8 +: 8] = d[b*8 +: 8];
          gold_mem[a[5:0]] = w;
          sbq.push_back('{port: p, data: 32'h0});
        end
      end
    end
  end

  task automatic drive(input int p, input logic v, input logic rd, input logic [AW-1:0] a,
                       input logic [31:0] d, input logic [3:0] m);
    if (p == 0) begin
      m0_cmd_valid = v; m0_cmd_read = rd; m0_cmd_addr = a; m0_cmd_wdata = d; m0_cmd_wmask = m;
    end else begin
      m1_cmd_valid = v; m1_cmd_read = rd; m1_cmd_addr = a; m1_cmd_wdata = d; m1_cmd_wmask = m;
    end
  endtask

  // Called just after a rising edge; returns just after the rising edge that starts the response cycle.
  task automatic issue(input int p, input logic rd, input logic [AW-1:0] a,
                       input logic [31:0] d, input logic [3:0] m, output int lat);
    int  n;
    bit  got;
    got = 1'b0;
    drive(p, 1'b1, rd, a, d, m);
    for (n = 0; n < 30 && !got; n++) begin
      @(negedge clk);
      got = (p == 0) ? m0_cmd_ready : m1_cmd_ready;
    end
    chk("issue_accept", got, 1'b1);
    lat = n - 1;
    @(posedge clk); #1;
    drive(p, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ctrl"}, {m0_cmd_ready, m1_cmd_ready, m0_rsp_valid, m1_rsp_valid, ram_cs, ram_we,
                         ram_ls, ram_ds, ram_sd, ram_wem, ram_addr}, '0);
    chk({tag, "_rdata"}, {m0_rsp_rdata, m1_rsp_rdata}, '0);
    chk({tag, "_din"}, ram_din, '0);
  endtask

  // Starts just after the rising edge following the last busy cycle.
  task automatic check_sleep_entry();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("ls_low_while_counting", ram_ls, 1'b0);
    end
    @(negedge clk);
    chk("ls_after_idle", ram_ls, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic rand_cmd(input int p, input bit allow);
    logic v;
    v = allow && ($urandom_range(0, 99) < 60);
    drive(p, v, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 63)), $urandom,
          4'($urandom_range(0, 15)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    int          lat;
    logic [31:0] init10;
    bit          a0, a1;
    bit          exp0;
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    m0_rsp_ready = 1'b1;
    m1_rsp_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      logic [31:0] v;
      v = $urandom;
      macro_mem[i] = v;
      gold_mem[i] = v;
    end
    init10 = gold_mem[16];

    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset_async");
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_held");
    rst_n = 1'b1;

    // Four idle cycles after reset, then light sleep.
    check_sleep_entry();

    // Wake from sleep: seen, WAKE, grant, response.
    drive(0, 1'b1, 1'b1, AW'(16), '0, '0);
    @(negedge clk);
    chk("wake_c0_ls", ram_ls, 1'b1);
    chk("wake_c0_cs", ram_cs, 1'b0);
    @(negedge clk);
    chk("wake_c1_ls", ram_ls, 1'b0);
    chk("wake_c1_cs", ram_cs, 1'b0);
    chk("wake_c1_ready", m0_cmd_ready, 1'b0);
    @(negedge clk);
    chk("wake_c2_cs", ram_cs, 1'b1);
    chk("wake_c2_ready", m0_cmd_ready, 1'b1);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    chk("wake_c3_valid", m0_rsp_valid, 1'b1);
    chk("wake_c3_rdata", m0_rsp_rdata, init10);
    @(posedge clk); #1;

    // Single write then read.
    issue(0, 1'b0, AW'(16), 32'hDEADBEEF, 4'hF, lat);
    chk("wr_latency", lat, 0);
    @(negedge clk);
    chk("wr_rsp_valid", m0_rsp_valid, 1'b1);
    chk("wr_rsp_rdata", m0_rsp_rdata, 32'h0);
    @(posedge clk); #1;
    issue(0, 1'b1, AW'(16), '0, '0, lat);
    chk("rd_latency", lat, 0);
    @(negedge clk);
    chk("rd_rsp_valid", m0_rsp_valid, 1'b1);
    chk("rd_rsp_rdata", m0_rsp_rdata, 32'hDEADBEEF);
    @(posedge clk); #1;

    // Byte mask merge.
    issue(1, 1'b0, AW'(48), 32'hFFFFFFFF, 4'hF, lat);
    @(negedge clk); @(posedge clk); #1;
    issue(1, 1'b0, AW'(48), 32'h000000AA, 4'h1, lat);
    @(negedge clk); @(posedge clk); #1;
    issue(1, 1'b1, AW'(48), '0, '0, lat);
    @(negedge clk);
    chk("mask_rdata", m1_rsp_rdata, 32'hFFFFFFAA);
    @(posedge clk); #1;
    check_sleep_entry();

    // Contention from reset: both hold reads, grants alternate starting at m0.
    rst_n = 1'b0;
    drive(0, 1'b1, 1'b1, AW'(1), '0, '0);
    drive(1, 1'b1, 1'b1, AW'(2), '0, '0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      exp0 = (k % 2 == 0);
      chk("contend_m0_ready", m0_cmd_ready, exp0);
      chk("contend_m1_ready", m1_cmd_ready, !exp0);
    end
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk); @(posedge clk); #1;

    // Back-pressure on m1 while m0 waits.
    issue(1, 1'b0, AW'(32), 32'h12345678, 4'hF, lat);
    @(negedge clk); @(posedge clk); #1;
    drive(1, 1'b1, 1'b1, AW'(32), '0, '0);
    @(negedge clk);
    chk("bp_m1_accept", m1_cmd_ready, 1'b1);
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    m1_rsp_ready = 1'b0;
    drive(0, 1'b1, 1'b1, AW'(16), '0, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", m1_rsp_valid, 1'b1);
      chk("bp_rsp_rdata", m1_rsp_rdata, 32'h12345678);
      chk("bp_ram_cs", ram_cs, 1'b0);
      chk("bp_m0_blocked", m0_cmd_ready, 1'b0);
    end
    @(posedge clk); #1;
    m1_rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_rdata", m1_rsp_rdata, 32'h12345678);
    chk("bp_release_m0_grant", m0_cmd_ready, 1'b1);
    chk("bp_release_cs", ram_cs, 1'b1);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    chk("bp_m0_rdata", m0_rsp_rdata, 32'hDEADBEEF);
    @(posedge clk); #1;

    // Reset while a response is stalled.
    m0_rsp_ready = 1'b0;
    issue(0, 1'b1, AW'(48), '0, '0, lat);
    @(negedge clk);
    chk("rst_stall_valid", m0_rsp_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset_mid_stall");
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m0_rsp_ready = 1'b1;
    issue(0, 1'b1, AW'(32), '0, '0, lat);
    chk("post_reset_latency", lat, 0);
    @(negedge clk);
    chk("post_reset_rdata", m0_rsp_rdata, 32'h12345678);
    @(posedge clk); #1;

    // Randomized traffic; commands are held until accepted.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      a0 = m0_cmd_valid & m0_cmd_ready;
      a1 = m1_cmd_valid & m1_cmd_ready;
      @(posedge clk); #1;
      if (!m0_cmd_valid || a0) rand_cmd(0, (c % 100) < 85);
      if (!m1_cmd_valid || a1) rand_cmd(1, (c % 100) < 85);
      m0_rsp_ready = ($urandom_range(0, 99) < 70);
      m1_rsp_ready = ($urandom_range(0, 99) < 70);
    end
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    m0_rsp_ready = 1'b1;
    m1_rsp_ready = 1'b1;
    for (int i = 0; i < 50 && sbq.size() != 0; i++) @(negedge clk);
    chk("drain_outstanding", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/e203_dtcm_ram_arb.md
# e203_dtcm_ram_arb

Two-port arbiter and power sequencer in front of the DTCM SRAM macro inside `e203_srams`. It shares one single-port RAM between two ICB-style requesters using round-robin arbitration with one outstanding access. It returns responses with one-cycle RAM latency and a back-pressure holding register. After a programmable idle period it puts the macro into light sleep, and it wakes the macro when the next command arrives.

## Interface
Parameters:
- `AW`, 14, RAM word address width
- `DW`, 32, data width
- `MW`, 4, write byte-mask width (DW/8)
- `IDLE_LS_CYC`, 16, idle cycles before light sleep; 0 disables sleep; max 255

Ports:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `mN_cmd_valid` (N=0,1)  in  1  command request
- `mN_cmd_ready`  out  1  command accepted this cycle
- `mN_cmd_read`  in  1  1=read, 0=write
- `mN_cmd_addr`  in  AW  word address
- `mN_cmd_wdata`  in  DW  write data
- `mN_cmd_wmask`  in  MW  byte enables
- `mN_rsp_valid`  out  1  response available
- `mN_rsp_ready`  in  1  response consumed
- `mN_rsp_rdata`  out  DW  read data; 0 for writes
- `ram_cs`, `ram_we`  out  1  macro chip select / write enable
- `ram_addr`  out  AW; `ram_wem`  out  MW; `ram_din`  out  DW
- `ram_dout`  in  DW  macro read data, valid the cycle after `ram_cs`
- `ram_ls`  out  1  light sleep; `ram_ds`, `ram_sd`  out  1  tied 0

## Operation
- States: ACTIVE, SLEEP, WAKE. Reset state is ACTIVE.
- ACTIVE:
  - A grant is possible when `free = !pend | (pend & owner rsp_valid & owner rsp_ready)`.
  - If one port is valid, that port is granted.
  - If both ports are valid, the port selected by `rr_ptr` is granted, and `rr_ptr` moves to the other port.
  - `rr_ptr` does not change on a single-requester grant.
- Grant behaviour:
  - The granted port sees `mN_cmd_ready=1`.
  - `ram_cs=1` and `ram_we=!cmd_read`.
  - `addr`, `wdata` and `wmask` pass through combinationally.
  - When `ram_we=0`, `ram_wem` is driven as 0.
- Pending response tracking:
  - On a grant, `pend` is set and `owner` and `is_rd` are registered.
  - `pend` clears on handshake of the owner's response unless a new grant happens in the same cycle.
- Response data:
  - In the first cycle of a pending read, the response data is `ram_dout`.
  - If that first response is not consumed, `ram_dout` is captured into `hold_q`, and `hold_q` is presented until the handshake.
  - Write responses return 0.
  - The non-owner port's `rsp_valid` is 0.
- Idle counter:
  - `idle_cnt` is 8 bits.
  - It increments in ACTIVE when there is no grant, no `pend` and no `cmd_valid`.
  - It clears on any of those conditions.
  - When `idle_cnt == IDLE_LS_CYC-1` and the block is still idle, the state goes to SLEEP.
- SLEEP: `ram_ls=1` and no grants. Any `cmd_valid` moves the state to WAKE.
- WAKE: `ram_ls=0` and no grants for one cycle, then the state goes to ACTIVE.
- With `IDLE_LS_CYC=0` the state never leaves ACTIVE.
- A `cmd_valid` deasserted during WAKE still completes the transition to ACTIVE.

## Timing
- Reset values:
  - All outputs are 0, including `ram_ls`.
  - `rr_ptr=0`, `pend=0`, `idle_cnt=0`, `hold_q=0`.
- Latency:
  - Command-to-response is 1 cycle.
  - Throughput is one access per cycle when `rsp_ready` is held high.
- Back-pressure: while a response is stalled, both `cmd_ready` outputs are 0. No command is lost, and the RAM is not accessed.
- Wake penalty from SLEEP:
  - Cycle 0: `cmd_valid` is seen.
  - Cycle 1: WAKE.
  - Cycle 2: earliest grant.
  - Cycle 3: response.
- Reset asserted mid-access: `pend` clears and any outstanding response is dropped.

## Test plan
- Single read: m0 writes 0xDEADBEEF to addr 0x10 with mask 0xF, then reads addr 0x10 -> `m0_rsp_valid` 1 cycle after each `cmd_ready`; read `rdata=0xDEADBEEF`; write response `rdata=0`.
- Contention: m0 and m1 both hold read valid for 4 cycles from reset -> grants m0,m1,m0,m1; each response goes to the correct port.
- Back-pressure: m1 reads addr 0x20 (data 0x12345678) with `m1_rsp_ready=0` for 3 cycles while m0 is valid -> `m1_rsp_rdata` stable at 0x12345678; no `ram_cs` for 3 cycles; m0 granted in the handshake cycle.
- Byte mask: write 0xFFFFFFFF, then write 0x000000AA with mask 0x1, then read -> 0xFFFFFFAA.
- Sleep/wake with `IDLE_LS_CYC=4`:
  - 4 idle cycles -> `ram_ls=1`.
  - m0 read -> `ram_ls` low next cycle; `ram_cs` 2 cycles after `cmd_valid`; data correct.
- Reset during stalled response -> all outputs 0, state ACTIVE, next read served normally.
